// File: rtl/ir_nec_pkg.sv
// ir_nec_pkg: shared definitions for the NEC infrared transmitter.
//   - state_t and the ST_* FSM state encodings
//   - NEC segment lengths, in units of 562.5 us
//   - is_mark(): true for the states that drive the LED
//   - nec_frame(): builds the 32-bit payload that is sent LSB first
package ir_nec_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_LEAD_MARK  = 3'd1;
  localparam state_t ST_LEAD_SPACE = 3'd2;
  localparam state_t ST_BIT_MARK   = 3'd3;
  localparam state_t ST_BIT_SPACE  = 3'd4;
  localparam state_t ST_STOP_MARK  = 3'd5;
  localparam state_t ST_GAP        = 3'd6;

  // Segment lengths in units. They share the 5-bit width of the segment counter.
  localparam logic [4:0] LEAD_MARK_U  = 5'd16;
  localparam logic [4:0] LEAD_SPACE_U = 5'd8;
  localparam logic [4:0] RPT_SPACE_U  = 5'd4;
  localparam logic [4:0] ZERO_SPACE_U = 5'd1;
  localparam logic [4:0] ONE_SPACE_U  = 5'd3;
  localparam int unsigned BITS_N      = 32;
  localparam logic [7:0] FRAME_U      = 8'd192;

  function automatic logic is_mark(input state_t s);
    return (s == ST_LEAD_MARK) || (s == ST_BIT_MARK) || (s == ST_STOP_MARK);
  endfunction

  function automatic logic [31:0] nec_frame(input logic [7:0] addr, input logic [7:0] cmd);
    return {~cmd, cmd, ~addr, addr};
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// ir_carrier_gen: square-wave carrier used for IR marks.
//   clk_i    system clock
//   reset_i  asynchronous active-high reset
//   clr_i    restart the carrier; the next level is 1 and the phase is 0
//   en_i     carrier running; when low, the level is held at 0
//   level_o  registered carrier level; it toggles every CARRIER_HALF cycles
module ir_carrier_gen #(
  parameter int unsigned CARRIER_HALF = 658
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic level_o
);

  localparam int unsigned PH_W = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CARRIER_HALF - 1);

  logic [PH_W-1:0] phase_q, phase_d;
  logic            level_q, level_d;

  // Next phase and next level: clear has priority, so each mark begins high
  always_comb begin
    phase_d = phase_q;
    level_d = level_q;
    if (clr_i) begin
      phase_d = '0;
      level_d = 1'b1;
    end else if (en_i) begin
      if (phase_q == PH_LAST) begin
        phase_d = '0;
        level_d = ~level_q;
      end else begin
        phase_d = phase_q + PH_W'(1);
        level_d = level_q;
      end
    end else begin
      phase_d = '0;
      level_d = 1'b0;
    end
  end

  // Phase and level registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      phase_q <= '0;
      level_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/ir_nec_tx.sv
// ir_nec_tx: NEC-protocol infrared transmitter.
//   clk        system clock (single domain)
//   reset      asynchronous active-high reset
//   in_valid   request valid; it is accepted only while in_ready is high
//   in_ready   the block is idle and can take a request
//   in_repeat  send a repeat code; in_addr and in_cmd are not used for it
//   in_addr    NEC address
//   in_cmd     NEC command
//   ir_tx      LED drive; 1 = LED on
//   busy       a frame is in progress
//   done       one-cycle pulse on the cycle the block returns to idle
// Build option: define IR_NEC_TX_CARRIER_EN to modulate the marks with the
// CARRIER_HALF carrier. Without it, marks are a solid 1 (envelope only).
module ir_nec_tx
  import ir_nec_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES  = 28125,
  parameter int unsigned CARRIER_HALF = 658
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_repeat,
  input  logic [7:0] in_addr,
  input  logic [7:0] in_cmd,
  output logic       ir_tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned UNIT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [UNIT_W-1:0] unit_q, unit_d;
  logic [4:0]        seg_q, seg_d;
  logic [7:0]        frame_q, frame_d;
  logic [4:0]        bit_q, bit_d;
  logic [31:0]       shreg_q, shreg_d;
  logic              rpt_q, rpt_d;
  logic              in_ready_q, busy_q, done_q;

  logic       tick_s;
  logic       seg_end_s;
  logic [4:0] seg_dur_s;

  assign tick_s    = (state_q != ST_IDLE) && (unit_q == UNIT_LAST);
  assign seg_end_s = tick_s && (seg_q == (seg_dur_s - 5'd1));

  // Length of the current segment in units; idle and gap do not use it
  always_comb begin
    seg_dur_s = 5'd1;
    case (state_q)
      ST_LEAD_MARK:  seg_dur_s = LEAD_MARK_U;
      ST_LEAD_SPACE: seg_dur_s = rpt_q ? RPT_SPACE_U : LEAD_SPACE_U;
      ST_BIT_SPACE:  seg_dur_s = shreg_q[0] ? ONE_SPACE_U : ZERO_SPACE_U;
      default:       seg_dur_s = 5'd1;
    endcase
  end

  // Counters and next FSM state
  always_comb begin
    state_d = state_q;
    unit_d  = unit_q;
    seg_d   = seg_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    rpt_d   = rpt_q;

    if (state_q != ST_IDLE) begin
      unit_d  = tick_s ? '0 : (unit_q + UNIT_W'(1));
      frame_d = tick_s ? (frame_q + 8'd1) : frame_q;
      seg_d   = seg_end_s ? 5'd0 : (tick_s ? (seg_q + 5'd1) : seg_q);
    end else begin
      unit_d  = unit_q;
      frame_d = frame_q;
      seg_d   = seg_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_LEAD_MARK;
          shreg_d = nec_frame(in_addr, in_cmd);
          rpt_d   = in_repeat;
          unit_d  = '0;
          seg_d   = 5'd0;
          frame_d = 8'd0;
          bit_d   = 5'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LEAD_MARK: begin
        if (seg_end_s) begin
          state_d = ST_LEAD_SPACE;
        end else begin
          state_d = ST_LEAD_MARK;
        end
      end
      ST_LEAD_SPACE: begin
        if (seg_end_s) begin
          state_d = rpt_q ? ST_STOP_MARK : ST_BIT_MARK;
        end else begin
          state_d = ST_LEAD_SPACE;
        end
      end
      ST_BIT_MARK: begin
        if (seg_end_s) begin
          state_d = ST_BIT_SPACE;
        end else begin
          state_d = ST_BIT_MARK;
        end
      end
      ST_BIT_SPACE: begin
        // The space length depends on shreg_q[0], so the shift happens only at its end
        if (seg_end_s) begin
          shreg_d = {1'b0, shreg_q[31:1]};
          bit_d   = bit_q + 5'd1;
          state_d = (bit_q == 5'(BITS_N - 1)) ? ST_STOP_MARK : ST_BIT_MARK;
        end else begin
          state_d = ST_BIT_SPACE;
        end
      end
      ST_STOP_MARK: begin
        if (seg_end_s) begin
          state_d = ST_GAP;
        end else begin
          state_d = ST_STOP_MARK;
        end
      end
      ST_GAP: begin
        // The gap pads every frame to the same total length, counted from the accept
        if (tick_s && (frame_q == (FRAME_U - 8'd1))) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GAP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, counters and registered handshake/status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      unit_q     <= '0;
      seg_q      <= 5'd0;
      frame_q    <= 8'd0;
      bit_q      <= 5'd0;
      shreg_q    <= 32'd0;
      rpt_q      <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      unit_q     <= unit_d;
      seg_q      <= seg_d;
      frame_q    <= frame_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      rpt_q      <= rpt_d;
      in_ready_q <= (state_d == ST_IDLE);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_q == ST_GAP) && (state_d == ST_IDLE);
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef IR_NEC_TX_CARRIER_EN
  logic car_clr_s, car_en_s, car_level_s;

  // The carrier restarts on the first cycle of every mark
  assign car_en_s  = is_mark(state_d);
  assign car_clr_s = is_mark(state_d) && !is_mark(state_q);

  ir_carrier_gen #(
    .CARRIER_HALF(CARRIER_HALF)
  ) u_carrier (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (car_clr_s),
    .en_i    (car_en_s),
    .level_o (car_level_s)
  );

  assign ir_tx = car_level_s;
`else
  logic mark_q;

  // Envelope-only drive: the LED is on for the whole of every mark
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mark_q <= 1'b0;
    end else begin
      mark_q <= is_mark(state_d);
    end
  end

  assign ir_tx = mark_q;
`endif

endmodule

// File: tb/tb_ir_nec_tx.sv
// tb_ir_nec_tx: directed, self-checking bench for ir_nec_tx. It uses
// UNIT_CYCLES=4 and CARRIER_HALF=1, so one NEC unit is 4 clk cycles and a
// frame is 768 cycles. Each frame is compared cycle by cycle against an
// expected waveform that the bench builds from the NEC segment timing. The
// bench also checks hand-computed totals, the done timing and the handshake.
module tb_ir_nec_tx;

  localparam int FRAME_CYC = 768;
`ifdef IR_NEC_TX_CARRIER_EN
  localparam bit CAR = 1'b1;
`else
  localparam bit CAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       in_repeat;
  logic [7:0] in_addr;
  logic [7:0] in_cmd;
  logic       ir_tx;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_bad = 0;

  logic exp_w [0:FRAME_CYC];

  typedef struct {
    bit         rpt;
    logic [7:0] addr;
    logic [7:0] cmd;
    int         exp_high;
    int         exp_end;
  } vec_t;

  vec_t tbl [5];

  ir_nec_tx #(
    .UNIT_CYCLES  (4),
    .CARRIER_HALF (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_repeat (in_repeat),
    .in_addr   (in_addr),
    .in_cmd    (in_cmd),
    .ir_tx     (ir_tx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Write a mark of len cycles that starts at cycle start
  task automatic put_mark(input int start, input int len);
    for (int o = 0; o < len; o++) begin
      exp_w[start + o] = CAR ? ((o % 2) == 0) : 1'b1;
    end
  endtask

  // Build the expected ir_tx waveform from NEC timing (1 unit = 4 cycles)
  task automatic build_exp(input bit rpt, input logic [7:0] a, input logic [7:0] c);
    logic [31:0] data;
    int p;
    for (int i = 0; i <= FRAME_CYC; i++) exp_w[i] = 1'b0;
    data = {~c, c, ~a, a};
    put_mark(0, 64);
    p = rpt ? 80 : 96;
    if (!rpt) begin
      for (int i = 0; i < 32; i++) begin
        put_mark(p, 4);
        p = p + 4 + (data[i] ? 12 : 4);
      end
    end
    put_mark(p, 4);
  endtask

  // Send one request and check its whole frame. poke_t >= 0 pulses in_valid
  // on that cycle. chain keeps in_valid high with the next request.
  task automatic run_frame(input string tag, input bit rpt, input logic [7:0] a,
                           input logic [7:0] c, input int exp_high, input int exp_end,
                           input int poke_t, input bit chain, input bit n_rpt,
                           input logic [7:0] n_a, input logic [7:0] n_c);
    int first_bad, highs, last_end, done_cnt, done_t, busy_end, rdy_end;
    first_bad = -1; highs = 0; last_end = 0; done_cnt = 0; done_t = -1;
    busy_end = -1; rdy_end = -1;
    build_exp(rpt, a, c);
    chk({tag, "_rdy_pre"}, in_ready, 1);
    in_valid = 1'b1; in_repeat = rpt; in_addr = a; in_cmd = c;
    @(posedge clk); #1;
    if (chain) begin
      in_repeat = n_rpt; in_addr = n_a; in_cmd = n_c;
    end else begin
      in_valid = 1'b0;
    end
    chk({tag, "_busy_start"}, busy, 1);
    chk({tag, "_rdy_start"}, in_ready, 0);
    for (int t = 0; t <= FRAME_CYC; t++) begin
      if (t > 0) begin
        @(posedge clk); #1;
      end
      if ((ir_tx !== exp_w[t]) && (first_bad < 0)) first_bad = t;
      if (ir_tx === 1'b1) begin
        highs++;
        last_end = t + 1;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_t = t;
      end
      if (t == FRAME_CYC) begin
        busy_end = busy;
        rdy_end  = in_ready;
      end
      if (t == poke_t) begin
        chk({tag, "_poke_rdy"}, in_ready, 0);
        in_valid = 1'b1; in_repeat = 1'b0; in_addr = 8'hEE; in_cmd = 8'h11;
      end else if (t == poke_t + 1) begin
        in_valid = 1'b0;
      end
    end
    chk({tag, "_wave_first_bad_cycle"}, first_bad, -1);
    chk({tag, "_high_cycles"}, highs, exp_high);
    chk({tag, "_last_mark_end"}, last_end, exp_end);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_done_cycle"}, done_t, FRAME_CYC);
    chk({tag, "_busy_end"}, busy_end, 0);
    chk({tag, "_rdy_end"}, rdy_end, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    int hi_d, hi_r;
    hi_d = CAR ? 98 : 196;
    hi_r = CAR ? 34 : 68;
    tbl[0] = '{rpt: 1'b0, addr: 8'h00, cmd: 8'h45, exp_high: hi_d, exp_end: 484};
    tbl[1] = '{rpt: 1'b1, addr: 8'hA5, cmd: 8'h3C, exp_high: hi_r, exp_end: 84};
    tbl[2] = '{rpt: 1'b0, addr: 8'hFF, cmd: 8'h00, exp_high: hi_d, exp_end: 484};
    tbl[3] = '{rpt: 1'b0, addr: 8'h5A, cmd: 8'hC3, exp_high: hi_d, exp_end: 484};
    tbl[4] = '{rpt: 1'b0, addr: 8'h01, cmd: 8'h80, exp_high: hi_d, exp_end: 484};

    reset = 1'b1; in_valid = 1'b0; in_repeat = 1'b0; in_addr = 8'h00; in_cmd = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", ir_tx, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rdy", in_ready, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    chk("idle_rdy", in_ready, 1);

    for (int i = 0; i < 5; i++) begin
      run_frame($sformatf("vec%0d", i), tbl[i].rpt, tbl[i].addr, tbl[i].cmd,
                tbl[i].exp_high, tbl[i].exp_end, -5, 1'b0, 1'b0, 8'h00, 8'h00);
    end

    // A request during the bit phase is ignored and causes no second frame
    run_frame("poke", 1'b0, 8'h00, 8'h45, hi_d, 484, 200, 1'b0, 1'b0, 8'h00, 8'h00);
    dcnt = 0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      if ((done === 1'b1) || (busy === 1'b1)) dcnt++;
    end
    chk("poke_no_second_frame", dcnt, 0);

    // Reset in the middle of the leader mark
    in_valid = 1'b1; in_repeat = 1'b0; in_addr = 8'h00; in_cmd = 8'h45;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    chk("midrst_pre_busy", busy, 1);
    chk("midrst_pre_tx", ir_tx, 1);
    reset = 1'b1;
    #1;
    chk("midrst_tx", ir_tx, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rdy", in_ready, 1);
    chk("midrst_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_frame("after_rst", 1'b0, 8'h00, 8'h45, hi_d, 484, -5, 1'b0, 1'b0, 8'h00, 8'h00);

    // Two back-to-back requests with in_valid held high
    run_frame("b2b_a", 1'b0, 8'h12, 8'h34, hi_d, 484, -5, 1'b1, 1'b0, 8'h56, 8'h78);
    run_frame("b2b_b", 1'b0, 8'h56, 8'h78, hi_d, 484, -5, 1'b0, 1'b0, 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
